// File: rtl/hf_reader_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hf_reader_frame_sequencer
// Description : ISO14443-A reader-side frame sequencer. Sends bytes as
//               Modified-Miller carrier pauses (SOF, data, odd parity, EOF),
//               then listens for the tag's first response bit and reports
//               the frame-delay time in carrier cycles, or a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module hf_reader_frame_sequencer #(
  parameter int unsigned PAUSE_LEN = 32,
  parameter logic [15:0] MIN_FDT   = 16'd1100,
  parameter logic [15:0] TIMEOUT   = 16'd9000
) (
  input  logic        osc_clk,
  input  logic        nreset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  input  logic        rx_mod,
  output logic        mod_pause,
  output logic [2:0]  mode,
  output logic        busy,
  output logic        done,
  output logic        rsp,
  output logic        timeout,
  output logic        underrun,
  output logic [15:0] fdt_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_EOF0   = 3'd4,
    ST_EOFY   = 3'd5,
    ST_LISTEN = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SEQ_X = 2'd0,
    SEQ_Y = 2'd1,
    SEQ_Z = 2'd2
  } seq_t;

  localparam logic [2:0] MODE_READER_MOD    = 3'b100;
  localparam logic [2:0] MODE_READER_LISTEN = 3'b011;
  localparam logic [7:0] PAUSE_W            = 8'(PAUSE_LEN);

  state_t      state_q, state_d;
  logic [6:0]  ph_q, ph_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        prev_q, prev_d;
  logic        mod_pause_q, mod_pause_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        rsp_q, rsp_d;
  logic        timeout_q, timeout_d;
  logic        underrun_q, underrun_d;
  logic [15:0] fdt_q, fdt_d;

  logic        in_frame;
  logic        period_end;
  logic        cur_bit;
  logic        in_window;
  seq_t        seq;

  assign in_frame   = (state_q != ST_IDLE) && (state_q != ST_LISTEN);
  assign period_end = (ph_q == 7'd127);

  // Logical bit of the current period and its Miller sequence / pause window.
  always_comb begin
    cur_bit   = 1'b0;
    seq       = SEQ_Y;
    in_window = 1'b0;
    case (state_q)
      ST_DATA:   cur_bit = data_q[bit_q];
      ST_PARITY: cur_bit = ~^data_q;
      default:   cur_bit = 1'b0;
    endcase
    if (state_q == ST_SOF) begin
      seq = SEQ_Z;
    end else if ((state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_EOF0)) begin
      if (cur_bit)     seq = SEQ_X;
      else if (prev_q) seq = SEQ_Y;
      else             seq = SEQ_Z;
    end
    case (seq)
      SEQ_Z:   in_window = ({1'b0, ph_q} < PAUSE_W);
      SEQ_X:   in_window = ({1'b0, ph_q} >= 8'd64) && ({1'b0, ph_q} < (8'd64 + PAUSE_W));
      default: in_window = 1'b0;
    endcase
  end

  // Next-state, byte handshake, fdt counter and completion status; abort wins.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q + 7'd1;
    bit_d       = bit_q;
    data_d      = data_q;
    last_d      = last_q;
    prev_d      = prev_q;
    mod_pause_d = in_frame & in_window;
    tx_ready    = 1'b0;
    done_d      = 1'b0;
    rsp_d       = 1'b0;
    timeout_d   = 1'b0;
    underrun_d  = 1'b0;
    fdt_d       = fdt_q;
    cnt_d       = (cnt_q != 16'hFFFF) ? (cnt_q + 16'd1) : cnt_q;

    if (in_frame && period_end) prev_d = cur_bit;

    case (state_q)
      ST_IDLE: begin
        ph_d  = 7'd0;
        bit_d = 3'd0;
        if (start && tx_valid) begin
          state_d  = ST_SOF;
          data_d   = tx_data;
          last_d   = tx_last;
          prev_d   = 1'b0;
          tx_ready = 1'b1;
        end
      end
      ST_SOF: begin
        if (period_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (period_end) begin
          if (bit_q == 3'd7) state_d = ST_PARITY;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (period_end) begin
          if (last_q) begin
            state_d = ST_EOF0;
          end else if (tx_valid) begin
            state_d  = ST_DATA;
            data_d   = tx_data;
            last_d   = tx_last;
            bit_d    = 3'd0;
            tx_ready = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            underrun_d  = 1'b1;
            mod_pause_d = 1'b0;
          end
        end
      end
      ST_EOF0: begin
        if (period_end) state_d = ST_EOFY;
      end
      ST_EOFY: begin
        if (period_end) state_d = ST_LISTEN;
      end
      ST_LISTEN: begin
        if (cnt_q >= TIMEOUT) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          fdt_d     = TIMEOUT;
        end else if (rx_mod && (cnt_q >= MIN_FDT)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          rsp_d   = 1'b1;
          fdt_d   = cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      mod_pause_d = 1'b0;
      tx_ready    = 1'b0;
      done_d      = 1'b0;
      rsp_d       = 1'b0;
      timeout_d   = 1'b0;
      underrun_d  = 1'b0;
      fdt_d       = fdt_q;
      data_d      = data_q;
      last_d      = last_q;
    end

    // Every pause end restarts the fdt count, so the last one leaves it
    // referenced to the final pause of the frame.
    if (mod_pause_q && !mod_pause_d) cnt_d = 16'd0;
  end

  // State and datapath registers, on the carrier falling edge.
  always_ff @(negedge osc_clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      ph_q        <= 7'd0;
      bit_q       <= 3'd0;
      data_q      <= 8'd0;
      last_q      <= 1'b0;
      prev_q      <= 1'b0;
      mod_pause_q <= 1'b0;
      cnt_q       <= 16'd0;
      done_q      <= 1'b0;
      rsp_q       <= 1'b0;
      timeout_q   <= 1'b0;
      underrun_q  <= 1'b0;
      fdt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      last_q      <= last_d;
      prev_q      <= prev_d;
      mod_pause_q <= mod_pause_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rsp_q       <= rsp_d;
      timeout_q   <= timeout_d;
      underrun_q  <= underrun_d;
      fdt_q       <= fdt_d;
    end
  end

  assign mod_pause = mod_pause_q;
  assign mode      = in_frame ? MODE_READER_MOD : MODE_READER_LISTEN;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign rsp       = rsp_q;
  assign timeout   = timeout_q;
  assign underrun  = underrun_q;
  assign fdt_count = fdt_q;

endmodule
`default_nettype wire

// File: tb/tb_hf_reader_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hf_reader_frame_sequencer
// Description : Self-checking bench for hf_reader_frame_sequencer. A frame
//               model built from the Miller rules predicts the pause/mode
//               waveform; directed transactions check response, echo
//               rejection, timeout, multi-byte, underrun, abort and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hf_reader_frame_sequencer;

  localparam int PAUSE_LEN = 32;
  localparam int MIN_FDT   = 1100;
  localparam int TIMEOUT   = 9000;

  logic        osc_clk  = 1'b0;
  logic        nreset   = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [7:0]  tx_data  = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_last  = 1'b0;
  logic        rx_mod   = 1'b0;
  logic        tx_ready;
  logic        mod_pause;
  logic [2:0]  mode;
  logic        busy;
  logic        done;
  logic        rsp;
  logic        timeout;
  logic        underrun;
  logic [15:0] fdt_count;

  hf_reader_frame_sequencer #(
    .PAUSE_LEN (PAUSE_LEN),
    .MIN_FDT   (16'(MIN_FDT)),
    .TIMEOUT   (16'(TIMEOUT))
  ) dut (
    .osc_clk   (osc_clk),
    .nreset    (nreset),
    .start     (start),
    .abort     (abort),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .rx_mod    (rx_mod),
    .mod_pause (mod_pause),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .rsp       (rsp),
    .timeout   (timeout),
    .underrun  (underrun),
    .fdt_count (fdt_count)
  );

  // Carrier clock; DUT acts on the falling edge, the bench on the rising edge.
  always #5 osc_clk = ~osc_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model: one Miller sequence per bit period ----------
  // 0 = Y (no pause), 1 = X (mid-period pause), 2 = Z (period-start pause)
  logic [7:0] frame_bytes[$];
  bit         model_underrun;
  int         seq_q[$];

  function automatic int miller(input bit b, input bit prev);
    if (b) return 1;
    return prev ? 0 : 2;
  endfunction

  function automatic void build_model();
    bit prev;
    bit b;
    int ones;
    seq_q.delete();
    seq_q.push_back(2);
    prev = 1'b0;
    foreach (frame_bytes[i]) begin
      ones = 0;
      for (int k = 0; k < 8; k++) begin
        b = frame_bytes[i][k];
        ones += int'(b);
        seq_q.push_back(miller(b, prev));
        prev = b;
      end
      b = ((ones % 2) == 0);
      seq_q.push_back(miller(b, prev));
      prev = b;
    end
    if (!model_underrun) begin
      seq_q.push_back(miller(1'b0, prev));
      seq_q.push_back(0);
    end
  endfunction

  // Expected mod_pause in frame cycle f (f=0 is the first cycle mode=READER_MOD);
  // the output is registered, so it shows the window of the previous cycle.
  function automatic bit exp_pause(input int f);
    int p;
    int ph;
    if (f < 1) return 1'b0;
    p  = (f - 1) / 128;
    ph = (f - 1) % 128;
    if (p >= seq_q.size()) return 1'b0;
    if (seq_q[p] == 2) return (ph < PAUSE_LEN);
    if (seq_q[p] == 1) return (ph >= 64) && (ph < 64 + PAUSE_LEN);
    return 1'b0;
  endfunction

  function automatic int model_last_pause_end();
    int e = -1;
    for (int k = 1; k <= seq_q.size() * 128 + 1; k++)
      if (exp_pause(k - 1) && !exp_pause(k)) e = k;
    return e;
  endfunction

  // ---------------- per-cycle compare process ---------------------------------
  bit   mon_en     = 1'b1;
  bit   in_frame   = 1'b0;
  int   f          = 0;
  int   mode_cnt   = 0;
  int   ready_cnt  = 0;
  int   done_cnt   = 0;
  logic prev_pause = 1'b0;
  int   rise_q[$];
  int   fall_q[$];

  // Compare mod_pause/mode with the model on every frame cycle.
  always @(posedge osc_clk) begin
    #2;
    if (tx_ready === 1'b1) ready_cnt++;
    if (done === 1'b1) done_cnt++;
    if (mon_en) begin
      if (!in_frame && (mode === 3'b100)) begin
        in_frame = 1'b1;
        f = 0;
      end
      if (in_frame) begin
        if (f <= seq_q.size() * 128 + 4) begin
          check("mod_pause_wave", mod_pause, exp_pause(f));
          check("mode_wave", mode, (f < seq_q.size() * 128) ? 3'b100 : 3'b011);
          if (mode === 3'b100) mode_cnt++;
          if (mod_pause === 1'b1 && prev_pause === 1'b0) rise_q.push_back(f);
          if (mod_pause === 1'b0 && prev_pause === 1'b1) fall_q.push_back(f);
        end
        f++;
      end
    end
    prev_pause = mod_pause;
  end

  // ---------------- stimulus helpers ------------------------------------------
  task automatic prep(input bit und);
    model_underrun = und;
    build_model();
    in_frame  = 1'b0;
    rise_q.delete();
    fall_q.delete();
    mode_cnt  = 0;
    ready_cnt = 0;
    done_cnt  = 0;
  endtask

  // Returns at the rising edge inside frame cycle 0.
  task automatic start_frame(input logic [7:0] d, input logic last);
    @(posedge osc_clk);
    start    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = last;
    #1 check("tx_ready_at_start", tx_ready, 1'b1);
    @(posedge osc_clk);
    start = 1'b0;
  endtask

  task automatic drive_rx_at(input int target);
    bit hit = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge osc_clk);
      if (in_frame && f == target) begin
        rx_mod = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("rx_target_reached", 1'b0, 1'b1);
  endtask

  task automatic wait_done(input int bound, output int at_f);
    bit got = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(posedge osc_clk);
      #3;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    at_f = f - 1;
    if (!got) check("done_within_bound", 1'b0, 1'b1);
  endtask

  task automatic after_done(input bit chk_fdt, input int exp_fdt);
    @(posedge osc_clk);
    #3;
    check("done_one_cycle", done, 1'b0);
    check("rsp_cleared", rsp, 1'b0);
    check("timeout_cleared", timeout, 1'b0);
    check("underrun_cleared", underrun, 1'b0);
    check("busy_after_done", busy, 1'b0);
    if (chk_fdt) check("fdt_holds", fdt_count, exp_fdt);
  endtask

  task automatic check_pauses(input int exp_ready);
    int mr[$];
    repeat (6) @(posedge osc_clk);
    for (int k = 1; k <= seq_q.size() * 128 + 1; k++)
      if (!exp_pause(k - 1) && exp_pause(k)) mr.push_back(k);
    check("pause_count", rise_q.size(), mr.size());
    foreach (mr[i]) if (i < rise_q.size()) check("pause_start", rise_q[i], mr[i]);
    foreach (fall_q[i]) if (i < rise_q.size()) check("pause_width", fall_q[i] - rise_q[i], PAUSE_LEN);
    check("tx_ready_pulses", ready_cnt, exp_ready);
    check("done_pulses", done_cnt, 1);
  endtask

  // ---------------- directed sequence -----------------------------------------
  int lit_rel[10] = '{0, 192, 384, 512, 640, 768, 896, 1024, 1152, 1280};
  int fe;
  int df;
  int rf;
  bit hit;

  initial begin
    // Reset values.
    repeat (3) @(posedge osc_clk);
    #1;
    check("rst_mod_pause", mod_pause, 1'b0);
    check("rst_mode", mode, 3'b011);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rsp", rsp, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_fdt", fdt_count, 16'd0);
    @(posedge osc_clk);
    nreset = 1'b1;
    repeat (2) @(posedge osc_clk);

    // start without tx_valid is ignored.
    start = 1'b1;
    #1 check("start_no_valid_ready", tx_ready, 1'b0);
    @(posedge osc_clk);
    start = 1'b0;
    #1 check("start_no_valid_busy", busy, 1'b0);

    // 8'h01 single byte, response held from 1200 cycles after the last pause.
    frame_bytes.delete();
    frame_bytes.push_back(8'h01);
    prep(1'b0);
    start_frame(8'h01, 1'b1);
    tx_valid = 1'b0;
    check("model_periods_1byte", seq_q.size(), 12);
    fe = model_last_pause_end();
    check("model_last_pause_end", fe, 1313);
    drive_rx_at(fe + 1200);
    wait_done(20000, df);
    rx_mod = 1'b0;
    check("rsp_flag", rsp, 1'b1);
    check("rsp_timeout_flag", timeout, 1'b0);
    check("rsp_underrun_flag", underrun, 1'b0);
    check("rsp_fdt", fdt_count, 16'd1200);
    check("rsp_busy", busy, 1'b0);
    check("rsp_done_cycle", df, fe + 1201);
    after_done(1'b1, 1200);
    check_pauses(1);
    check("mode_len_1byte", mode_cnt, 1536);
    if (rise_q.size() == 10)
      foreach (lit_rel[i]) check("pause_rel_literal", rise_q[i] - rise_q[0], lit_rel[i]);

    // Echo rejection: one pulse at 500 cycles, then timeout.
    prep(1'b0);
    start_frame(8'h01, 1'b1);
    tx_valid = 1'b0;
    fe = model_last_pause_end();
    drive_rx_at(fe + 500);
    @(posedge osc_clk);
    rx_mod = 1'b0;
    wait_done(12000, df);
    check("echo_timeout_flag", timeout, 1'b1);
    check("echo_rsp_flag", rsp, 1'b0);
    check("echo_fdt", fdt_count, 16'd9000);
    check("echo_done_cycle", df, fe + TIMEOUT + 1);
    after_done(1'b1, 9000);
    check_pauses(1);

    // MIN_FDT boundary: rx_mod held from counter 1099, honoured at 1100.
    prep(1'b0);
    start_frame(8'h01, 1'b1);
    tx_valid = 1'b0;
    fe = model_last_pause_end();
    drive_rx_at(fe + MIN_FDT - 1);
    wait_done(20000, df);
    rx_mod = 1'b0;
    check("minfdt_rsp", rsp, 1'b1);
    check("minfdt_fdt", fdt_count, 16'd1100);
    check("minfdt_done_cycle", df, fe + MIN_FDT + 1);
    after_done(1'b1, 1100);
    check_pauses(1);

    // Two-byte frame 8'hFF then 8'h00.
    frame_bytes.delete();
    frame_bytes.push_back(8'hFF);
    frame_bytes.push_back(8'h00);
    prep(1'b0);
    start_frame(8'hFF, 1'b0);
    tx_data = 8'h00;
    tx_last = 1'b1;
    hit = 1'b0;
    rf  = -1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge osc_clk);
      #1;
      if (tx_ready === 1'b1) begin
        hit = 1'b1;
        rf  = f;
        break;
      end
    end
    check("byte2_ready_seen", hit, 1'b1);
    check("byte2_ready_cycle", rf, 1279);
    @(posedge osc_clk);
    tx_valid = 1'b0;
    check("model_periods_2byte", seq_q.size(), 21);
    check("model_parity1_is_x", seq_q[9], 1);
    check("model_parity2_is_x", seq_q[18], 1);
    fe = model_last_pause_end();
    drive_rx_at(fe + 1500);
    wait_done(20000, df);
    rx_mod = 1'b0;
    check("two_rsp", rsp, 1'b1);
    check("two_fdt", fdt_count, 16'd1500);
    after_done(1'b1, 1500);
    check_pauses(2);

    // Underrun: 8'hA5 with tx_last=0 and no next byte.
    frame_bytes.delete();
    frame_bytes.push_back(8'hA5);
    prep(1'b1);
    start_frame(8'hA5, 1'b0);
    tx_valid = 1'b0;
    wait_done(3000, df);
    check("und_flag", underrun, 1'b1);
    check("und_rsp", rsp, 1'b0);
    check("und_timeout", timeout, 1'b0);
    check("und_mod_pause", mod_pause, 1'b0);
    check("und_busy", busy, 1'b0);
    check("und_done_cycle", df, 1280);
    after_done(1'b0, 0);
    check_pauses(1);

    // Abort beats a simultaneous start in IDLE.
    mon_en = 1'b0;
    done_cnt = 0;
    @(posedge osc_clk);
    start = 1'b1; tx_valid = 1'b1; tx_data = 8'h01; tx_last = 1'b1; abort = 1'b1;
    #1 check("abort_start_ready", tx_ready, 1'b0);
    @(posedge osc_clk);
    start = 1'b0; tx_valid = 1'b0; abort = 1'b0;
    #1 check("abort_start_busy", busy, 1'b0);

    // Abort at DATA bit 3, mid-pause.
    start_frame(8'h01, 1'b1);
    tx_valid = 1'b0;
    repeat (520) @(posedge osc_clk);
    #1 check("abort_pre_pause", mod_pause, 1'b1);
    abort = 1'b1;
    @(posedge osc_clk);
    abort = 1'b0;
    #1;
    check("abort_mod_pause", mod_pause, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_mode", mode, 3'b011);
    repeat (20) @(posedge osc_clk);
    check("abort_no_done", done_cnt, 0);

    // nreset low mid-pause clears outputs asynchronously.
    start_frame(8'h01, 1'b1);
    tx_valid = 1'b0;
    repeat (520) @(posedge osc_clk);
    #1 check("reset_pre_pause", mod_pause, 1'b1);
    #1 nreset = 1'b0;
    #1;
    check("arst_mod_pause", mod_pause, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_mode", mode, 3'b011);
    check("arst_done", done, 1'b0);
    check("arst_fdt", fdt_count, 16'd0);
    @(posedge osc_clk);
    nreset = 1'b1;
    repeat (3) @(posedge osc_clk);
    #1 check("post_reset_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hf_reader_frame_sequencer.md
Name: hf_reader_frame_sequencer

Overview:
- Reader-side transaction controller for the ISO14443-A HF datapath, clocked by the 13.56 MHz carrier.
- Takes bytes from the ARM-side byte interface and emits Modified-Miller carrier pauses (the coil modulation signal), driving the datapath mode select to READER_MOD.
- After the frame it switches the datapath to READER_LISTEN and watches the modulation detector output for the tag's first response bit.
- Reports the frame-delay time in carrier cycles, or a timeout.

Parameters:
- PAUSE_LEN, 32, pause length in carrier cycles (1..63).
- MIN_FDT, 16'd1100, cycles after the last pause end before rx_mod is honoured.
- TIMEOUT, 16'd9000, cycles after the last pause end at which listening gives up (> MIN_FDT).

Ports:
- osc_clk  in  1  carrier clock; all logic on negedge osc_clk, matching the HF datapath.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  begin a transaction; honoured only in IDLE.
- abort  in  1  synchronous abort; highest priority.
- tx_data  in  8  byte to send, LSB first.
- tx_valid  in  1  tx_data is valid.
- tx_last  in  1  qualifies tx_data as the final byte of the frame.
- tx_ready  out  1  one-cycle pulse: tx_data consumed.
- rx_mod  in  1  modulation detector output (curbit).
- mod_pause  out  1  1 = drop carrier; drives the coil modulation signal.
- mode  out  3  3'b100 (READER_MOD) in SOF/DATA/PARITY/EOF; 3'b011 (READER_LISTEN) otherwise.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- rsp  out  1  valid with done: 1 = response detected.
- timeout  out  1  valid with done: 1 = no response.
- underrun  out  1  valid with done: tx_valid was absent at a byte boundary.
- fdt_count  out  16  cycles from the end of the last pause to the first honoured rx_mod.

Behaviour:
- Reset values: mod_pause=0, mode=3'b011, tx_ready=0, busy=0, done=0, rsp=0, timeout=0, underrun=0, fdt_count=0, state=IDLE.
- States: IDLE, SOF, DATA, PARITY, EOF0, EOFY, LISTEN.
- Bit period: 128 cycles, timed by a 7-bit phase counter ph (0..127).
- Pause placement within a period, by sequence type:
  - Z: mod_pause=1 for ph in [0, PAUSE_LEN-1].
  - X: mod_pause=1 for ph in [64, 64+PAUSE_LEN-1].
  - Y: no pause.
  - mod_pause is registered, so it is asserted the cycle after ph enters the window.
- Miller encoding rules:
  - Logic 1 → X.
  - Logic 0 → Y if the previous bit was 1, else Z.
  - SOF is Z, with the previous bit treated as 0.
- IDLE → SOF on start && tx_valid. tx_data/tx_last are latched and tx_ready pulses in the same cycle; ph is cleared.
  - start without tx_valid is ignored.
- SOF → DATA after one period.
- DATA: 8 periods, bits LSB first. → PARITY.
- PARITY: one period sending the odd parity bit (the 1 needed so the count of ones over 9 bits is odd).
  - At the end of the period: if the latched tx_last=1 → EOF0.
  - Else if tx_valid=1: latch the next byte, pulse tx_ready, → DATA.
  - Else → IDLE with done=1, underrun=1, mod_pause forced to 0.
- EOF0: logic 0 per the Miller rules. EOFY: one Y period.
- The fdt counter clears at the cycle mod_pause falls for the last time (inside PARITY or EOF0), then counts every cycle, saturating at 16'hFFFF.
- After EOFY → LISTEN (mode=3'b011).
- LISTEN, while counter < TIMEOUT:
  - rx_mod=1 with counter ≥ MIN_FDT → fdt_count=counter, done=1, rsp=1, → IDLE.
  - rx_mod before MIN_FDT is ignored (reader echo).
- Counter == TIMEOUT → done=1, timeout=1, fdt_count=TIMEOUT, → IDLE.
- rsp/timeout/underrun are valid only while done=1; they clear the following cycle.
- fdt_count holds until the next completion.
- abort in any state: next edge → IDLE, mod_pause=0, no done pulse. Takes priority over a simultaneous rx_mod, timeout or start.
- start while busy is ignored.
- tx_ready never pulses outside the start and byte-boundary cycles.
- nreset asserted mid-frame forces mod_pause=0 immediately (asynchronous).

Test Plan:
- Frame timing, tx_data=8'h01, tx_last=1, start:
  - Bits 1,0,0,0,0,0,0,0; parity 0.
  - Exactly 10 pauses of 32 cycles, at frame cycles 0, 192, 384, 512, 640, 768, 896, 1024, 1152, 1280.
  - mode=3'b100 for 1536 cycles, then 3'b011.
- Response: as above, rx_mod=1 held from 1200 cycles after the last pause end → done with rsp=1, fdt_count=1200.
- Echo rejection: rx_mod pulse at cycle 500 after the pause end, no later pulse → ignored; done with timeout=1, fdt_count=9000.
- Two-byte frame: 8'hFF then 8'h00 (tx_last=1) → tx_ready pulses twice, 18 data/parity periods, parity bits 1 then 1.
- Underrun: first byte tx_last=0, tx_valid low at the boundary → done with underrun=1, mod_pause=0, busy=0 next cycle.
- Abort: abort at DATA bit 3, mid-pause → mod_pause=0 and busy=0 next edge, no done pulse. Repeat with nreset low mid-pause → outputs at reset values asynchronously.
